// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin front end for one shared 32-bit execute unit (ADD/SUB/AND/OR).
// A single operation is in flight at a time. A requester is granted in IDLE,
// its operands are captured, the result is computed in EXEC and registered,
// and the result is held in RESP until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate among valid requesters, grant one and capture it
// EXEC    | compute from the captured operands, register result and id
// RESP    | present rsp_valid and hold result until rsp_ready
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [2*NUM_REQ-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDX_W-1:0]       rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [1:0]         r_op;
  logic [IDX_W-1:0]   r_id;
  logic [31:0]        r_rsp_result;
  logic [IDX_W-1:0]   r_rsp_id;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic               w_accept;
  logic               w_rsp_fire;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [1:0]         w_sel_op;
  logic [31:0]        w_alu_res;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Operand mux for the current winner and pointer advance past it.
  always_comb begin
    w_sel_a  = req_a[32*int'(w_win) +: 32];
    w_sel_b  = req_b[32*int'(w_win) +: 32];
    w_sel_op = req_op[2*int'(w_win) +: 2];
    if (int'(w_win) == NUM_REQ - 1) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_win + IDX_W'(1);
    end
  end

  // Shared execute datapath working only from captured values.
  always_comb begin
    w_alu_res = '0;
    case (r_op)
      OP_ADD:  w_alu_res = r_a + r_b;
      OP_SUB:  w_alu_res = r_a - r_b;
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      default: w_alu_res = '0;
    endcase
  end

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_rsp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_req_ready[w_win] = 1'b1;
          w_accept           = 1'b1;
          w_state_nxt        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted request and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_a      <= w_sel_a;
      r_b      <= w_sel_b;
      r_op     <= w_sel_op;
      r_id     <= w_win;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Register result and owner at the end of EXEC; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= w_alu_res;
      r_rsp_id     <= r_id;
    end
  end

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_fire && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != ST_IDLE);
  assign op_count   = r_op_count;

endmodule
